rggen_round_robin_arbiter: RTL and testbench

Registered round-robin arbiter. It selects one of `N` requesters, holds that grant until the downstream consumer signals completion, then rotates priority. It produces the one-hot grant vector consumed directly by the one-hot-to-binary stage of the register-block datapath. The same stage also exports the grant as a binary index.

---
 rtl/rggen_round_robin_arbiter.sv | 107 ++++++++++
 tb/tb_rggen_round_robin_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_round_robin_arbiter.sv
// Registered round-robin arbiter: grants one of N requesters, holds the grant
// until i_done, then rotates priority to the requester after the released one.
module rggen_round_robin_arbiter #(
    parameter  int N           = 2,
    localparam int INDEX_WIDTH = (N >= 2) ? $clog2(N) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N-1:0]           i_request,
    input  logic                   i_done,
    output logic                   o_grant_valid,
    output logic [N-1:0]           o_grant,
    output logic [INDEX_WIDTH-1:0] o_grant_index
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] GRANTED = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [N-1:0]           grant_q, grant_d;

    logic [INDEX_WIDTH-1:0] next_ptr;
    logic [INDEX_WIDTH-1:0] base;
    logic [2*N-1:0]         rotated;
    logic                   win_found;
    logic [INDEX_WIDTH-1:0] win_index;
    logic [N-1:0]           win_grant;

    // Priority pointer as it will be after releasing the current owner.
    always_comb begin
        int nxt;
        nxt = int'(index_q) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        next_ptr = nxt[INDEX_WIDTH-1:0];
    end

    // A release re-arbitrates against the post-release pointer, so the
    // current owner is scanned last and wins only when it is the sole request.
    assign base    = (state_q == GRANTED) ? next_ptr : ptr_q;
    assign rotated = {i_request, i_request} >> base;

    always_comb begin
        int j;
        // NOTE: every combinationally assigned signal gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        win_found = 1'b0;
        win_index = '0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            if (!win_found && rotated[i]) begin
                win_found = 1'b1;
                j         = int'(base) + i;
                if (j >= N) begin
                    j = j - N;
                end
                win_index = j[INDEX_WIDTH-1:0];
            end
        end
        win_grant = win_found ? (N'(1) << win_index) : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        index_d = index_q;
        grant_d = grant_q;
        if (state_q == IDLE || i_done) begin
            if (state_q == GRANTED) begin
                ptr_d = next_ptr;
            end
            if (win_found) begin
                state_d = GRANTED;
                index_d = win_index;
                grant_d = win_grant;
            end else begin
                state_d = IDLE;
                index_d = '0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            index_q <= '0;
            grant_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            index_q <= index_d;
            grant_q <= grant_d;
        end
    end

    assign o_grant_valid = (state_q == GRANTED);
    assign o_grant       = grant_q;
    assign o_grant_index = index_q;

endmodule

// File: tb/tb_rggen_round_robin_arbiter.sv
// Self-checking bench: three arbiter builds (N=4, N=3, N=1) checked against
// directed expectations and a behavioural round-robin model under random traffic.
module tb_rggen_round_robin_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_v [3];
    logic       done_v[3];

    logic       valid_a, valid_b, valid_c;
    logic [3:0] grant_a;
    logic [2:0] grant_b;
    logic [0:0] grant_c;
    logic [1:0] idx_a, idx_b;
    logic [0:0] idx_c;

    wire        v_v[3];
    wire  [3:0] g_v[3];
    wire  [1:0] i_v[3];

    assign v_v[0] = valid_a;
    assign v_v[1] = valid_b;
    assign v_v[2] = valid_c;
    assign g_v[0] = grant_a;
    assign g_v[1] = {1'b0, grant_b};
    assign g_v[2] = {3'b000, grant_c};
    assign i_v[0] = idx_a;
    assign i_v[1] = idx_b;
    assign i_v[2] = {1'b0, idx_c};

    int checks   = 0;
    int failures = 0;

    // Behavioural model state per build.
    int m_n[3] = '{4, 3, 1};
    int m_valid[3];
    int m_idx[3];
    int m_ptr[3];

    rggen_round_robin_arbiter #(.N(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req_v[0]), .i_done(done_v[0]),
        .o_grant_valid(valid_a), .o_grant(grant_a), .o_grant_index(idx_a)
    );

    rggen_round_robin_arbiter #(.N(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req_v[1][2:0]), .i_done(done_v[1]),
        .o_grant_valid(valid_b), .o_grant(grant_b), .o_grant_index(idx_b)
    );

    rggen_round_robin_arbiter #(.N(1)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req_v[2][0:0]), .i_done(done_v[2]),
        .o_grant_valid(valid_c), .o_grant(grant_c), .o_grant_index(idx_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time=%0t, limit=2000000)", $time);
        $fatal(1);
    end

    // First requester found scanning upward from p modulo n, or -1 if none.
    function automatic int first_from(int n, int p, logic [3:0] r);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (((r >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 0;
            m_idx[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    task automatic model_step(int d);
        int w;
        if (m_valid[d] == 0) begin
            w = first_from(m_n[d], m_ptr[d], req_v[d]);
            if (w >= 0) begin
                m_valid[d] = 1;
                m_idx[d]   = w;
            end
        end else if (done_v[d]) begin
            m_ptr[d] = (m_idx[d] + 1) % m_n[d];
            w = first_from(m_n[d], m_ptr[d], req_v[d]);
            if (w >= 0) begin
                m_idx[d] = w;
            end else begin
                m_valid[d] = 0;
                m_idx[d]   = 0;
            end
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 3; d++) begin
            req_v[d]  = 4'd0;
            done_v[d] = 1'b0;
        end
    endtask

    // One rising edge; model sees the same inputs the DUTs sampled.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d);
        #1;
    endtask

    task automatic reset_all();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (v_v[d] !== 1'b0 || g_v[d] !== 4'd0 || i_v[d] !== 2'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: valid=%b grant=%b index=%0d, required 0/0/0",
                         d, v_v[d], g_v[d], i_v[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_request();
        reset_all();
        req_v[0] = 4'b0100;
        tick();
        checks++;
        if (valid_a !== 1'b1 || grant_a !== 4'b0100 || idx_a !== 2'd2) begin
            failures++;
            $display("FAIL single_grant: valid=%b grant=%b index=%0d, required 1/0100/2",
                     valid_a, grant_a, idx_a);
        end
        tick();
        checks++;
        if (grant_a !== 4'b0100 || idx_a !== 2'd2) begin
            failures++;
            $display("FAIL single_hold: grant=%b index=%0d, required 0100/2", grant_a, idx_a);
        end
        req_v[0]  = 4'b0000;
        done_v[0] = 1'b1;
        tick();
        checks++;
        if (valid_a !== 1'b0 || grant_a !== 4'b0000 || idx_a !== 2'd0) begin
            failures++;
            $display("FAIL single_release: valid=%b grant=%b index=%0d, required 0/0000/0",
                     valid_a, grant_a, idx_a);
        end
        done_v[0] = 1'b0;
        req_v[0]  = 4'b1111;
        tick();
        checks++;
        if (idx_a !== 2'd3 || grant_a !== 4'b1000) begin
            failures++;
            $display("FAIL ptr_after_release: grant=%b index=%0d, required 1000/3", grant_a, idx_a);
        end
        clear_inputs();
    endtask

    task automatic test_rotation();
        int exp_seq[4] = '{1, 2, 3, 0};
        reset_all();
        req_v[0] = 4'b1111;
        tick();
        checks++;
        if (valid_a !== 1'b1 || idx_a !== 2'd0) begin
            failures++;
            $display("FAIL rotation_first: valid=%b index=%0d, required 1/0", valid_a, idx_a);
        end
        done_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid_a !== 1'b1 || idx_a !== 2'(exp_seq[k]) || grant_a !== (4'd1 << exp_seq[k])) begin
                failures++;
                $display("FAIL rotation_step%0d: valid=%b grant=%b index=%0d, required 1/index %0d",
                         k, valid_a, grant_a, idx_a, exp_seq[k]);
            end
        end
        done_v[0] = 1'b0;
    endtask

    // Continues from the rotation state: index 0 granted, pointer 0.
    task automatic test_hold_without_done();
        req_v[0]  = 4'b1111;
        done_v[0] = 1'b1;
        tick();
        checks++;
        if (idx_a !== 2'd1) begin
            failures++;
            $display("FAIL hold_setup: index=%0d, required 1", idx_a);
        end
        done_v[0] = 1'b0;
        req_v[0]  = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (valid_a !== 1'b1 || grant_a !== 4'b0010 || idx_a !== 2'd1) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b grant=%b index=%0d, required 1/0010/1",
                         k, valid_a, grant_a, idx_a);
            end
        end
    endtask

    // Continues from the hold state: index 1 granted.
    task automatic test_wrap_around();
        req_v[0]  = 4'b0100;
        done_v[0] = 1'b1;
        tick();
        checks++;
        if (idx_a !== 2'd2) begin
            failures++;
            $display("FAIL wrap_setup: index=%0d, required 2", idx_a);
        end
        req_v[0] = 4'b0011;
        tick();
        checks++;
        if (valid_a !== 1'b1 || grant_a !== 4'b0001 || idx_a !== 2'd0) begin
            failures++;
            $display("FAIL wrap_to_zero: valid=%b grant=%b index=%0d, required 1/0001/0",
                     valid_a, grant_a, idx_a);
        end
        tick();
        checks++;
        if (grant_a !== 4'b0010 || idx_a !== 2'd1) begin
            failures++;
            $display("FAIL wrap_next: grant=%b index=%0d, required 0010/1", grant_a, idx_a);
        end
        req_v[0] = 4'b0000;
        tick();
        checks++;
        if (valid_a !== 1'b0 || grant_a !== 4'b0000) begin
            failures++;
            $display("FAIL wrap_idle: valid=%b grant=%b, required 0/0000", valid_a, grant_a);
        end
        clear_inputs();
    endtask

    task automatic test_sole_requester();
        req_v[1]  = 4'b0010;
        done_v[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (valid_b !== 1'b1 || grant_b !== 3'b010 || idx_b !== 2'd1) begin
                failures++;
                $display("FAIL sole_regrant%0d: valid=%b grant=%b index=%0d, required 1/010/1",
                         k, valid_b, grant_b, idx_b);
            end
        end
        req_v[1] = 4'b0000;
        tick();
        checks++;
        if (valid_b !== 1'b0 || grant_b !== 3'b000) begin
            failures++;
            $display("FAIL sole_release: valid=%b grant=%b, required 0/000", valid_b, grant_b);
        end
        clear_inputs();
    endtask

    task automatic test_mid_grant_reset();
        req_v[0] = 4'b0100;
        tick();
        checks++;
        if (idx_a !== 2'd2 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: valid=%b index=%0d, required 1/2", valid_a, idx_a);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (valid_a !== 1'b0 || grant_a !== 4'b0000 || idx_a !== 2'd0) begin
            failures++;
            $display("FAIL midreset_clear: valid=%b grant=%b index=%0d, required 0/0000/0",
                     valid_a, grant_a, idx_a);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        req_v[0] = 4'b1111;
        tick();
        checks++;
        if (idx_a !== 2'd0 || grant_a !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_restart: grant=%b index=%0d, required 0001/0", grant_a, idx_a);
        end
        clear_inputs();
        done_v[0] = 1'b1;
        tick();
        done_v[0] = 1'b0;
    endtask

    task automatic test_single_requester_build();
        req_v[2] = 4'b0001;
        tick();
        checks++;
        if (valid_c !== 1'b1 || grant_c !== 1'b1 || idx_c !== 1'b0) begin
            failures++;
            $display("FAIL n1_grant: valid=%b grant=%b index=%0d, required 1/1/0", valid_c, grant_c, idx_c);
        end
        done_v[2] = 1'b1;
        tick();
        checks++;
        if (valid_c !== 1'b1 || grant_c !== 1'b1) begin
            failures++;
            $display("FAIL n1_regrant: valid=%b grant=%b, required 1/1", valid_c, grant_c);
        end
        req_v[2] = 4'b0000;
        tick();
        checks++;
        if (valid_c !== 1'b0 || grant_c !== 1'b0 || idx_c !== 1'b0) begin
            failures++;
            $display("FAIL n1_release: valid=%b grant=%b index=%0d, required 0/0/0", valid_c, grant_c, idx_c);
        end
        clear_inputs();
    endtask

    task automatic test_random_traffic();
        reset_all();
        for (int n = 0; n < 400; n++) begin
            req_v[0]  = 4'($urandom_range(0, 15));
            req_v[1]  = {1'b0, 3'($urandom_range(0, 7))};
            req_v[2]  = {3'b000, 1'($urandom_range(0, 1))};
            if ($urandom_range(0, 3) == 0) req_v[0] = 4'd0;
            for (int d = 0; d < 3; d++) done_v[d] = ($urandom_range(0, 1) == 1);
            tick();
            for (int d = 0; d < 3; d++) begin
                logic [3:0] exp_g;
                exp_g = (m_valid[d] != 0) ? (4'd1 << m_idx[d]) : 4'd0;
                checks++;
                if (v_v[d] !== (m_valid[d] != 0) || g_v[d] !== exp_g || i_v[d] !== 2'(m_idx[d])) begin
                    failures++;
                    $display("FAIL random dut%0d cycle%0d: valid=%b grant=%b index=%0d, required %0d/%b/%0d",
                             d, n, v_v[d], g_v[d], i_v[d], m_valid[d], exp_g, m_idx[d]);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_request();
        test_rotation();
        test_hold_without_done();
        test_wrap_around();
        test_sole_requester();
        test_mid_grant_reset();
        test_single_requester_build();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
